layer_compositor: RTL and testbench

// - N-layer chroma-key compositor between the per-layer sprite/background BRAMs and the VGA output pins.
// - Aligns the address-phase control and sync signals to the BRAM read latency.
// - Selects the highest-priority opaque layer per pixel, with an optional half-transparency blend.
// - Drives registered RGB, sync and valid outputs.

---
 rtl/comp_pkg.sv | 21 ++
 rtl/pipe_delay.sv | 27 ++
 rtl/layer_compositor.sv | 162 ++++++++++++++++
 tb/tb_layer_compositor.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared constants and helpers for the layer compositor.
package comp_pkg;

  // Colour word of this codebase: R|G|B packed MSB->LSB.
  localparam int COLOR_W = 12;
  localparam int CH_W    = COLOR_W / 3;

  // Default chroma key and background colours.
  localparam logic [COLOR_W-1:0] DEF_KEY_COLOR = 12'hF0F;
  localparam logic [COLOR_W-1:0] DEF_BG_COLOR  = 12'h000;

  // Truncated average of one colour channel; the sum carries one extra bit
  // so the carry survives the halving.
  function automatic logic [CH_W-1:0] ch_avg(input logic [CH_W-1:0] a,
                                              input logic [CH_W-1:0] b);
    logic [CH_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CH_W:1];
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register whose stages all reset to INIT.
module pipe_delay #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift every cycle; synchronous reset loads INIT into every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/layer_compositor.sv
// N-layer chroma-key compositor feeding the VGA pins.
// Flow: control bus delayed RD_LAT cycles to meet BRAM data, stage 1 picks
// the top and under opaque colours, stage 2 applies blank/background/blend.
// Streaming interface: there is no ready. pix_valid only qualifies a pixel;
// the pipeline advances every cycle and every input cycle (valid or not)
// reaches the outputs exactly RD_LAT+2 cycles later, syncs included.
module layer_compositor
  import comp_pkg::*;
#(
  parameter int                 NUM_LAYERS = 4,
  parameter int                 COLOR_W    = 12,
  parameter int                 RD_LAT     = 1,
  parameter logic [COLOR_W-1:0] KEY_COLOR  = DEF_KEY_COLOR,
  parameter logic [COLOR_W-1:0] BG_COLOR   = DEF_BG_COLOR,
  parameter logic               SYNC_IDLE  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid_in,
  input  logic                          blank_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic [NUM_LAYERS-1:0]         layer_hit,
  input  logic [NUM_LAYERS-1:0]         layer_blend,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_data,
  output logic                          pix_valid_out,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic [COLOR_W-1:0]            color_out
);

  localparam int CHAN_W = COLOR_W / 3;
  localparam int CTRL_W = 4 + 2 * NUM_LAYERS;
  // Idle control word: not valid, blanked, syncs idle, no hits, no blends.
  localparam logic [CTRL_W-1:0] CTRL_INIT =
    {1'b0, 1'b1, SYNC_IDLE, SYNC_IDLE, {(2*NUM_LAYERS){1'b0}}};

  logic [CTRL_W-1:0]     ctrl_in;
  logic [CTRL_W-1:0]     ctrl_d;
  logic                  valid_d, blank_d, hsync_d, vsync_d;
  logic [NUM_LAYERS-1:0] hit_d, blend_d;

  assign ctrl_in = {pix_valid_in, blank_in, hsync_in, vsync_in, layer_hit, layer_blend};

  pipe_delay #(
    .WIDTH (CTRL_W),
    .DEPTH (RD_LAT),
    .INIT  (CTRL_INIT)
  ) u_ctrl_delay (
    .clk (clk),
    .rst (rst),
    .d   (ctrl_in),
    .q   (ctrl_d)
  );

  assign valid_d = ctrl_d[CTRL_W-1];
  assign blank_d = ctrl_d[CTRL_W-2];
  assign hsync_d = ctrl_d[CTRL_W-3];
  assign vsync_d = ctrl_d[CTRL_W-4];
  assign hit_d   = ctrl_d[NUM_LAYERS +: NUM_LAYERS];
  assign blend_d = ctrl_d[0 +: NUM_LAYERS];

  // Aligned stage: top = highest-index opaque layer, under = next opaque below.
  // Data of a non-hit layer is never looked at beyond the opacity gate.
  logic [NUM_LAYERS-1:0] opaque;
  logic [COLOR_W-1:0]    top_col, under_col;
  logic                  top_blend, found_top, found_under;

  // Descending scan so the first opaque layer met is the top one.
  always_comb begin
    opaque      = '0;
    top_col     = BG_COLOR;
    under_col   = BG_COLOR;
    top_blend   = 1'b0;
    found_top   = 1'b0;
    found_under = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      opaque[i] = hit_d[i] && (layer_data[i*COLOR_W +: COLOR_W] != KEY_COLOR);
      if (opaque[i]) begin
        if (!found_top) begin
          found_top = 1'b1;
          top_col   = layer_data[i*COLOR_W +: COLOR_W];
          top_blend = blend_d[i];
        end else if (!found_under) begin
          found_under = 1'b1;
          under_col   = layer_data[i*COLOR_W +: COLOR_W];
        end
      end
    end
  end

  // Stage 1 registers.
  logic [COLOR_W-1:0] s1_top, s1_under;
  logic               s1_blend, s1_any, s1_valid, s1_blank, s1_hsync, s1_vsync;

  // Capture the selection together with the aligned sync/valid/blank.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_top   <= '0;
      s1_under <= '0;
      s1_blend <= 1'b0;
      s1_any   <= 1'b0;
      s1_valid <= 1'b0;
      s1_blank <= 1'b1;
      s1_hsync <= SYNC_IDLE;
      s1_vsync <= SYNC_IDLE;
    end else begin
      s1_top   <= top_col;
      s1_under <= under_col;
      s1_blend <= top_blend;
      s1_any   <= found_top;
      s1_valid <= valid_d;
      s1_blank <= blank_d;
      s1_hsync <= hsync_d;
      s1_vsync <= vsync_d;
    end
  end

  // Half-transparency: per-channel truncated average of top and under.
  logic [COLOR_W-1:0] blend_col;

  if (CHAN_W == CH_W) begin : g_pkg_avg
    // Channel width matches the package helper.
    always_comb begin
      blend_col = '0;
      for (int c = 0; c < 3; c++) begin
        blend_col[c*CHAN_W +: CHAN_W] = ch_avg(s1_top[c*CHAN_W +: CHAN_W],
                                               s1_under[c*CHAN_W +: CHAN_W]);
      end
    end
  end else begin : g_local_avg
    logic [CHAN_W:0] sum;
    // Other channel widths: same truncated average computed locally.
    always_comb begin
      blend_col = '0;
      sum       = '0;
      for (int c = 0; c < 3; c++) begin
        sum = {1'b0, s1_top[c*CHAN_W +: CHAN_W]} + {1'b0, s1_under[c*CHAN_W +: CHAN_W]};
        blend_col[c*CHAN_W +: CHAN_W] = sum[CHAN_W:1];
      end
    end
  end

  // Stage 2: registered VGA outputs; blank wins, then background, then blend.
  always_ff @(posedge clk) begin
    if (rst) begin
      color_out     <= '0;
      pix_valid_out <= 1'b0;
      hsync_out     <= SYNC_IDLE;
      vsync_out     <= SYNC_IDLE;
    end else begin
      pix_valid_out <= s1_valid;
      hsync_out     <= s1_hsync;
      vsync_out     <= s1_vsync;
      if (s1_blank)      color_out <= '0;
      else if (!s1_any)  color_out <= BG_COLOR;
      else if (s1_blend) color_out <= blend_col;
      else               color_out <= s1_top;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: DUT A at default parameters, DUT B with
// RD_LAT=3 / NUM_LAYERS=6. Each bench-side BRAM model delays the address-phase
// data by RD_LAT; expected outputs are queued at each sampling edge.
module tb_layer_compositor;

  localparam int LAT_A = 3;
  localparam int LAT_B = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic rst_b;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUT A ----------------
  logic        a_valid, a_blank, a_hs, a_vs;
  logic [3:0]  a_hit, a_blend;
  logic [47:0] a_data;
  logic [47:0] layer_data_a;
  logic        pix_valid_out_a, hsync_out_a, vsync_out_a;
  logic [11:0] color_out_a;

  always @(posedge clk) layer_data_a <= a_data;

  layer_compositor u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .pix_valid_in  (a_valid),
    .blank_in      (a_blank),
    .hsync_in      (a_hs),
    .vsync_in      (a_vs),
    .layer_hit     (a_hit),
    .layer_blend   (a_blend),
    .layer_data    (layer_data_a),
    .pix_valid_out (pix_valid_out_a),
    .hsync_out     (hsync_out_a),
    .vsync_out     (vsync_out_a),
    .color_out     (color_out_a)
  );

  // ---------------- DUT B ----------------
  logic        b_valid, b_blank, b_hs, b_vs;
  logic [5:0]  b_hit, b_blend;
  logic [71:0] b_data;
  logic [71:0] bram_b [3];
  logic [71:0] layer_data_b;
  logic        pix_valid_out_b, hsync_out_b, vsync_out_b;
  logic [11:0] color_out_b;
  logic        b_en = 1'b0;

  always @(posedge clk) begin
    bram_b[0] <= b_data;
    bram_b[1] <= bram_b[0];
    bram_b[2] <= bram_b[1];
  end
  assign layer_data_b = bram_b[2];

  layer_compositor #(
    .NUM_LAYERS (6),
    .RD_LAT     (3)
  ) u_dut_b (
    .clk           (clk),
    .rst           (rst_b),
    .pix_valid_in  (b_valid),
    .blank_in      (b_blank),
    .hsync_in      (b_hs),
    .vsync_in      (b_vs),
    .layer_hit     (b_hit),
    .layer_blend   (b_blend),
    .layer_data    (layer_data_b),
    .pix_valid_out (pix_valid_out_b),
    .hsync_out     (hsync_out_b),
    .vsync_out     (vsync_out_b),
    .color_out     (color_out_b)
  );

  // ---------------- reference model / scoreboard ----------------
  // Expected word: {valid, hsync, vsync, colour}.
  logic [14:0] exp_q_a [$];
  logic [14:0] exp_q_b [$];
  logic [14:0] rst_exp = {1'b0, 1'b1, 1'b1, 12'h000};

  function automatic logic [14:0] ref_pix(input int n, input logic v, input logic b,
                                          input logic h, input logic s,
                                          input logic [5:0] hit, input logic [5:0] blend,
                                          input logic [71:0] data);
    logic [11:0] top, under, col, d;
    logic        ft, fu, tbl;
    int          t, u;
    top = 12'h000; under = 12'h000; col = 12'h000;
    ft = 1'b0; fu = 1'b0; tbl = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      d = data[i*12 +: 12];
      if (hit[i] === 1'b1 && d !== 12'hF0F) begin
        if (!ft) begin ft = 1'b1; top = d; tbl = blend[i]; end
        else if (!fu) begin fu = 1'b1; under = d; end
      end
    end
    if (b) col = 12'h000;
    else if (!ft) col = 12'h000;
    else if (tbl) begin
      for (int c = 0; c < 3; c++) begin
        t = int'(top[c*4 +: 4]);
        u = int'(under[c*4 +: 4]);
        col[c*4 +: 4] = 4'((t + u) / 2);
      end
    end else col = top;
    return {v, h, s, col};
  endfunction

  // Push the expected result of whatever is being sampled at this edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_q_a.delete();
      repeat (LAT_A) exp_q_a.push_back(rst_exp);
    end else begin
      exp_q_a.push_back(ref_pix(4, a_valid, a_blank, a_hs, a_vs, {2'b00, a_hit},
                                {2'b00, a_blend}, {24'h000000, a_data}));
    end
    if (b_en) begin
      if (rst_b) begin
        exp_q_b.delete();
        repeat (LAT_B) exp_q_b.push_back(rst_exp);
      end else begin
        exp_q_b.push_back(ref_pix(6, b_valid, b_blank, b_hs, b_vs, b_hit, b_blend, b_data));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_a(input logic v, input logic b, input logic h, input logic s,
                         input logic [3:0] hit, input logic [3:0] blend,
                         input logic [47:0] data);
    a_valid = v; a_blank = b; a_hs = h; a_vs = s;
    a_hit = hit; a_blend = blend; a_data = data;
    @(negedge clk);
  endtask

  task automatic idle_a();
    drive_a(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 48'h0);
  endtask

  task automatic drive_b(input logic v, input logic b, input logic h, input logic s,
                         input logic [5:0] hit, input logic [5:0] blend,
                         input logic [71:0] data);
    b_valid = v; b_blank = b; b_hs = h; b_vs = s;
    b_hit = hit; b_blend = blend; b_data = data;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [14:0] got, exp;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle_a();
      if (exp_q_a.size() >= LAT_A) begin
        exp = exp_q_a.pop_front();
        got = {pix_valid_out_a, hsync_out_a, vsync_out_a, color_out_a};
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL reset got=%h exp=%h", got, exp);
        end
      end
    end
    rst = 1'b0;
  endtask

  // One pixel in, plus trailing idle cycles to flush it out.
  task automatic test_pixels(input string name, input logic [3:0] hit,
                             input logic [3:0] blend, input logic [47:0] data,
                             input logic blank);
    logic [14:0] got, exp;
    for (int i = 0; i < LAT_A + 2; i++) begin
      if (i == 0) drive_a(1'b1, blank, 1'b1, 1'b1, hit, blend, data);
      else idle_a();
      if (exp_q_a.size() >= LAT_A) begin
        exp = exp_q_a.pop_front();
        got = {pix_valid_out_a, hsync_out_a, vsync_out_a, color_out_a};
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
      end
    end
  endtask

  // Fixed-latency check independent of the queue: 12'h123 exactly 3 cycles on.
  task automatic test_single_latency();
    logic [14:0] got, exp;
    int hit_cycle;
    hit_cycle = -1;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive_a(1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 4'b0000, {36'hxxxxxxxxx, 12'h123});
      else idle_a();
      if (pix_valid_out_a === 1'b1 && color_out_a === 12'h123 && hit_cycle < 0) hit_cycle = i;
      if (exp_q_a.size() >= LAT_A) begin
        exp = exp_q_a.pop_front();
        got = {pix_valid_out_a, hsync_out_a, vsync_out_a, color_out_a};
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL single got=%h exp=%h", got, exp);
        end
      end
    end
    // Sampled at negedge i: output has passed i+1 edges, so latency 3 -> i=2.
    checks++;
    if (hit_cycle !== 2) begin
      failures++; $display("FAIL single_latency got=%0d exp=%0d", hit_cycle, 2);
    end
  endtask

  task automatic test_hsync();
    logic [14:0] got, exp;
    int lows, total;
    lows = 0;
    total = 4 + 96 + LAT_A + 4;
    for (int i = 0; i < total; i++) begin
      drive_a(1'b1, 1'b0, !(i >= 4 && i < 100), 1'b1, 4'($urandom_range(0, 15)),
              4'h0, {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)});
      if (hsync_out_a === 1'b0) lows++;
      if (exp_q_a.size() >= LAT_A) begin
        exp = exp_q_a.pop_front();
        got = {pix_valid_out_a, hsync_out_a, vsync_out_a, color_out_a};
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL hsync got=%h exp=%h", got, exp);
        end
      end
    end
    checks++;
    if (lows !== 96) begin
      failures++; $display("FAIL hsync_width got=%0d exp=%0d", lows, 96);
    end
  endtask

  task automatic test_mid_reset();
    logic [14:0] got, exp;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) drive_a(1'b1, 1'b0, 1'(i != 5), 1'b0, 4'($urandom_range(1, 15)), 4'h0,
                         {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)});
      else if (i == 8) begin
        rst = 1'b1;
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, {4{12'h5A5}});
        rst = 1'b0;
        got = {pix_valid_out_a, hsync_out_a, vsync_out_a, color_out_a};
        checks++;
        if (got !== {1'b0, 1'b1, 1'b1, 12'h000}) begin
          failures++; $display("FAIL mid_reset_out got=%h exp=%h", got, {1'b0, 1'b1, 1'b1, 12'h000});
        end
      end
      else if (i < 13) drive_a(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 48'h0);
      else drive_a(1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 4'h0, {12'h000, 12'h3C7, 24'h000000});
      if (exp_q_a.size() >= LAT_A) begin
        exp = exp_q_a.pop_front();
        got = {pix_valid_out_a, hsync_out_a, vsync_out_a, color_out_a};
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL mid_reset got=%h exp=%h", got, exp);
        end
      end
    end
  endtask

  task automatic test_random_b();
    logic [14:0] got, exp;
    logic [71:0] data;
    logic [5:0]  hit;
    b_en = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 10000 + LAT_B + 2; i++) begin
      if (i == 2) rst_b = 1'b0;
      hit = 6'($urandom);
      for (int l = 0; l < 6; l++) begin
        if (hit[l] && $urandom_range(0, 3) == 0) data[l*12 +: 12] = 12'hF0F;
        else if (!hit[l] && $urandom_range(0, 1) == 0) data[l*12 +: 12] = 12'hxxx;
        else data[l*12 +: 12] = 12'($urandom);
      end
      drive_b(1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
              hit, 6'($urandom), data);
      if (exp_q_b.size() >= LAT_B) begin
        exp = exp_q_b.pop_front();
        got = {pix_valid_out_b, hsync_out_b, vsync_out_b, color_out_b};
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL random_b got=%h exp=%h", got, exp);
        end
      end
    end
    b_en = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; rst_b = 1'b1;
    b_valid = 1'b0; b_blank = 1'b1; b_hs = 1'b1; b_vs = 1'b1;
    b_hit = '0; b_blend = '0; b_data = '0;
    test_reset();
    test_single_latency();
    test_pixels("key_skip", 4'b0110, 4'b0000, {12'hxxx, 12'hF0F, 12'h0A0, 12'hxxx}, 1'b0);
    test_pixels("no_hit",   4'b0000, 4'b0000, {12'hxxx, 12'hxxx, 12'hxxx, 12'hxxx}, 1'b0);
    test_pixels("all_hit",  4'b1111, 4'b0000, {12'h444, 12'h333, 12'h222, 12'h111}, 1'b0);
    test_pixels("blend",    4'b1001, 4'b1000, {12'hE00, 12'hxxx, 12'hxxx, 12'h02C}, 1'b0);
    test_pixels("blend_bg", 4'b1000, 4'b1000, {12'hE00, 12'hxxx, 12'hxxx, 12'h02C}, 1'b0);
    test_pixels("blend_key_top", 4'b1001, 4'b1001, {12'hF0F, 12'h000, 12'h000, 12'h8F2}, 1'b0);
    test_pixels("blend_low_ignored", 4'b1100, 4'b0100, {12'hE00, 12'h0F0, 24'h000000}, 1'b0);
    test_pixels("blend_carry", 4'b0011, 4'b0010, {24'h000000, 12'hFFF, 12'hEEE}, 1'b0);
    test_pixels("blank",    4'b0010, 4'b0000, {12'h000, 12'h000, 12'hFFF, 12'h000}, 1'b1);
    test_hsync();
    test_mid_reset();
    for (int i = 0; i < LAT_A + 1; i++) begin
      test_pixels("back_to_back", 4'($urandom), 4'($urandom),
                  {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)}, 1'b0);
    end
    test_random_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
